// File: rtl/cnn_pkg.sv
// Shared widths, FSM state encoding and weight indexing for the 5x5 convolution sink.
package cnn_pkg;

  localparam int unsigned PIX_W  = 9;
  localparam int unsigned K      = 5;
  localparam int unsigned KK     = K * K;
  localparam int unsigned PROD_W = 2 * PIX_W;
  localparam int unsigned ACC_W  = 23;
  localparam int unsigned COL_W  = K * PIX_W;
  localparam int unsigned WIDX_W = 5;
  localparam int unsigned BIAS_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Flat weight index for kernel position (row, col).
  function automatic logic [WIDX_W-1:0] w_idx(input int unsigned row, input int unsigned col);
    return WIDX_W'(row * K + col);
  endfunction

endpackage

// File: rtl/conv_col5_mac.sv
// One window column: five signed pixel*weight products (S1) reduced to a column sum (S2).
module conv_col5_mac
  import cnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [COL_W-1:0]        col,
  input  logic [COL_W-1:0]        w_col,
  output logic signed [ACC_W-1:0] col_sum
);

  logic signed [PIX_W-1:0]  px     [K];
  logic signed [PIX_W-1:0]  wt     [K];
  logic signed [PROD_W-1:0] prod_q [K];
  logic signed [ACC_W-1:0]  sum_c;

  // Row slices are MSB-first: row 1 occupies the top PIX_W bits.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      px[r] = col[COL_W-1-r*PIX_W -: PIX_W];
      wt[r] = w_col[COL_W-1-r*PIX_W -: PIX_W];
    end
  end

  always_comb begin
    sum_c = '0;
    for (int r = 0; r < K; r++) sum_c = sum_c + ACC_W'(prod_q[r]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < K; r++) prod_q[r] <= '0;
      col_sum <= '0;
    end else begin
      for (int r = 0; r < K; r++) prod_q[r] <= PROD_W'(px[r]) * PROD_W'(wt[r]);
      col_sum <= sum_c;
    end
  end

endmodule

// File: rtl/win_5_5_conv_sink.sv
// Consumes 5x5 windows, convolves with bias, ReLU/shift/saturate, and writes one pixel per valid window.
module win_5_5_conv_sink
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned SHIFT  = 8,
  parameter int unsigned OUT_AW = 10
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic                     win_valid,
  input  logic [COL_W-1:0]         x_m_1,
  input  logic [COL_W-1:0]         x_m_2,
  input  logic [COL_W-1:0]         x_m_3,
  input  logic [COL_W-1:0]         x_m_4,
  input  logic [COL_W-1:0]         x_m_5,
  input  logic                     w_we,
  input  logic [WIDX_W-1:0]        w_addr,
  input  logic [PIX_W-1:0]         w_data,
  input  logic signed [BIAS_W-1:0] bias,
  output logic                     wr_en,
  output logic [OUT_AW-1:0]        wr_addr,
  output logic [PIX_W-1:0]         wr_data,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned ROWS = IMG_H - K + 1;
  localparam int unsigned C_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned R_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'(255);

  state_e state_q, state_d;
  logic   busy_d, done_d;

  logic [C_W-1:0]    c_q;
  logic [R_W-1:0]    ro_q;
  logic [OUT_AW-1:0] addr_q;
  logic              accept_c, keep_c, last_c;

  logic signed [PIX_W-1:0] w_q [KK];
  logic [COL_W-1:0]        x_col   [K];
  logic [COL_W-1:0]        w_col   [K];
  logic signed [ACC_W-1:0] col_sum [K];

  logic [2:0]              v_q;
  logic [OUT_AW-1:0]       a_q [3];
  logic signed [ACC_W-1:0] acc_d, acc_q, relu_c, shr_c;
  logic [PIX_W-1:0]        pix_c;

  assign accept_c = win_valid && (state_q == IDLE || state_q == RUN);
  assign keep_c   = accept_c && (c_q >= C_W'(K - 1));
  assign last_c   = accept_c && (c_q == C_W'(IMG_W - 1)) && (ro_q == R_W'(ROWS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE:    if (accept_c) state_d = last_c ? FLUSH : RUN;
      RUN:     if (last_c) state_d = FLUSH;
      FLUSH:   if (v_q == 3'b000) state_d = DONE;
      DONE:    if (start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN) || (state_d == FLUSH);
    done_d = (state_q == FLUSH) && (state_d == DONE);
  end

  // Position of the newest window pixel; ro_q counts rows from K-1, addr_q counts kept beats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c_q    <= '0;
      ro_q   <= '0;
      addr_q <= '0;
    end else if ((state_q == DONE && start) || last_c) begin
      c_q    <= '0;
      ro_q   <= '0;
      addr_q <= '0;
    end else if (accept_c) begin
      if (c_q == C_W'(IMG_W - 1)) begin
        c_q  <= '0;
        ro_q <= ro_q + R_W'(1);
      end else begin
        c_q <= c_q + C_W'(1);
      end
      if (keep_c) addr_q <= addr_q + OUT_AW'(1);
    end
  end

  // Weights are frozen while a frame is in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < KK; k++) w_q[k] <= '0;
    end else if (w_we && (state_q == IDLE || state_q == DONE) && (w_addr < WIDX_W'(KK))) begin
      w_q[w_addr] <= w_data;
    end
  end

  assign x_col[0] = x_m_1;
  assign x_col[1] = x_m_2;
  assign x_col[2] = x_m_3;
  assign x_col[3] = x_m_4;
  assign x_col[4] = x_m_5;

  always_comb begin
    for (int j = 0; j < K; j++) begin
      w_col[j] = '0;
      for (int r = 0; r < K; r++) w_col[j][COL_W-1-r*PIX_W -: PIX_W] = w_q[w_idx(r, j)];
    end
  end

  for (genvar j = 0; j < K; j++) begin : g_col
    conv_col5_mac u_col (
      .clk     (clk),
      .rstn    (rstn),
      .col     (x_col[j]),
      .w_col   (w_col[j]),
      .col_sum (col_sum[j])
    );
  end

  always_comb begin
    acc_d = ACC_W'(bias);
    for (int j = 0; j < K; j++) acc_d = acc_d + col_sum[j];
  end

  always_comb begin
    relu_c = acc_q[ACC_W-1] ? '0 : acc_q;
    shr_c  = relu_c >>> SHIFT;
    pix_c  = (shr_c > PIX_MAX) ? PIX_W'(255) : PIX_W'(shr_c);
  end

  // Valid/address tags travel alongside S1..S3 so bubbles produce no write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q     <= '0;
      for (int s = 0; s < 3; s++) a_q[s] <= '0;
      acc_q   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      v_q    <= {v_q[1:0], keep_c};
      a_q[0] <= addr_q;
      a_q[1] <= a_q[0];
      a_q[2] <= a_q[1];
      acc_q  <= acc_d;
      wr_en  <= v_q[2];
      if (v_q[2]) begin
        wr_addr <= a_q[2];
        wr_data <= pix_c;
      end
    end
  end

endmodule

// File: tb/tb_win_5_5_conv_sink.sv
// Randomized frame-level bench for win_5_5_conv_sink; two instances (SHIFT 0 and SHIFT 8) share stimulus.
module tb_win_5_5_conv_sink;

  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int K      = 5;
  localparam int OW     = IMG_W - K + 1;
  localparam int OH     = IMG_H - K + 1;
  localparam int NW     = OW * OH;
  localparam int NBEATS = OH * IMG_W;

  logic        clk = 1'b0;
  logic        rstn, start, win_valid, w_we;
  logic [44:0] x_m_1, x_m_2, x_m_3, x_m_4, x_m_5;
  logic [4:0]  w_addr;
  logic [8:0]  w_data;
  logic [15:0] bias;
  logic        wr_en0, busy0, done0, wr_en8, busy8, done8;
  logic [9:0]  wr_addr0, wr_addr8;
  logic [8:0]  wr_data0, wr_data8;

  int n_assert = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int wt  [25];
  int pix [IMG_H][IMG_W];
  int bias_i;

  typedef struct {
    int at;
    int addr;
    int d0;
    int d8;
  } exp_t;
  exp_t exp_q [$];

  always #5 clk = ~clk;

  win_5_5_conv_sink #(.IMG_W(IMG_W), .IMG_H(IMG_H), .SHIFT(0), .OUT_AW(10)) dut0 (
    .clk(clk), .rstn(rstn), .start(start), .win_valid(win_valid),
    .x_m_1(x_m_1), .x_m_2(x_m_2), .x_m_3(x_m_3), .x_m_4(x_m_4), .x_m_5(x_m_5),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .bias(bias),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .busy(busy0), .done(done0)
  );

  win_5_5_conv_sink #(.IMG_W(IMG_W), .IMG_H(IMG_H), .SHIFT(8), .OUT_AW(10)) dut8 (
    .clk(clk), .rstn(rstn), .start(start), .win_valid(win_valid),
    .x_m_1(x_m_1), .x_m_2(x_m_2), .x_m_3(x_m_3), .x_m_4(x_m_4), .x_m_5(x_m_5),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .bias(bias),
    .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8), .busy(busy8), .done(done8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Reference: full 5x5 dot product over the image, window newest pixel at (r, c).
  function automatic int conv_at(input int r, input int c);
    int s;
    s = bias_i;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        s += wt[i*5+j] * pix[r-4+i][c-4+j];
    return s;
  endfunction

  function automatic int post(input int acc, input int sh);
    int v;
    if (acc < 0) return 0;
    v = acc / (1 << sh);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic drive_window(input int r, input int c, input bit junk);
    logic [44:0] xm [5];
    int cc;
    int v;
    for (int j = 0; j < 5; j++) begin
      xm[j] = '0;
      for (int i = 0; i < 5; i++) begin
        cc = c - 4 + j;
        if (junk || cc < 0) v = int'($urandom_range(511));
        else v = pix[r-4+i][cc];
        xm[j][44-9*i -: 9] = 9'(v);
      end
    end
    x_m_1 = xm[0];
    x_m_2 = xm[1];
    x_m_3 = xm[2];
    x_m_4 = xm[3];
    x_m_5 = xm[4];
  endtask

  task automatic load_weights();
    for (int k = 0; k < 25; k++) begin
      w_we   = 1'b1;
      w_addr = 5'(k);
      w_data = 9'(wt[k]);
      tick();
    end
    w_addr = 5'(25 + int'($urandom_range(6)));
    w_data = 9'($urandom_range(511));
    tick();
    w_we = 1'b0;
    bias = 16'(bias_i);
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        pix[r][c] = lo + int'($urandom_range(hi - lo));
  endtask

  task automatic stream_frame(input int gap_pct, input int abort_at, input bit run_wwe);
    int   beat, writes, first_edge, done_edge, budget, r, c;
    bit   exp_wr, exp_busy, exp_done, finished;
    exp_t e;
    beat = 0; writes = 0; first_edge = -1; done_edge = -1; finished = 1'b0;
    exp_q.delete();
    budget = 4 * NBEATS + 100;
    while (!finished && budget > 0) begin
      budget--;
      if (beat < NBEATS && int'($urandom_range(99)) >= gap_pct) begin
        r = K - 1 + beat / IMG_W;
        c = beat % IMG_W;
        drive_window(r, c, 1'b0);
        win_valid = 1'b1;
        if (c >= K - 1) begin
          e.at   = edge_n + 4;
          e.addr = (r - (K - 1)) * OW + (c - (K - 1));
          e.d0   = post(conv_at(r, c), 0);
          e.d8   = post(conv_at(r, c), 8);
          exp_q.push_back(e);
        end
        if (beat == 0) first_edge = edge_n + 1;
        if (beat == NBEATS - 1) done_edge = edge_n + 5;
        beat++;
      end else begin
        drive_window(0, 0, 1'b1);
        win_valid = 1'b0;
      end
      if (run_wwe && first_edge >= 0 && edge_n >= first_edge) begin
        w_we   = 1'($urandom_range(1));
        w_addr = 5'($urandom_range(24));
        w_data = 9'($urandom_range(511));
      end
      tick();

      exp_wr = 1'b0;
      if (exp_q.size() > 0) exp_wr = (exp_q[0].at == edge_n);
      n_assert++;
      if (wr_en0 !== exp_wr || wr_en8 !== exp_wr) begin
        n_fail++;
        $display("FAIL wr_en @edge %0d: got %b/%b expected %b", edge_n, wr_en0, wr_en8, exp_wr);
      end
      if (exp_wr) begin
        e = exp_q.pop_front();
        writes++;
        n_assert++;
        if (wr_addr0 !== 10'(e.addr) || wr_addr8 !== 10'(e.addr)) begin
          n_fail++;
          $display("FAIL wr_addr write %0d: got %0d/%0d expected %0d", writes, wr_addr0, wr_addr8, e.addr);
        end
        n_assert++;
        if (wr_data0 !== 9'(e.d0)) begin
          n_fail++;
          $display("FAIL wr_data_sh0 addr %0d: got %0d expected %0d", e.addr, wr_data0, e.d0);
        end
        n_assert++;
        if (wr_data8 !== 9'(e.d8)) begin
          n_fail++;
          $display("FAIL wr_data_sh8 addr %0d: got %0d expected %0d", e.addr, wr_data8, e.d8);
        end
      end

      exp_busy = (first_edge >= 0) && (edge_n >= first_edge) && !(done_edge >= 0 && edge_n >= done_edge);
      exp_done = (done_edge >= 0) && (edge_n == done_edge);
      n_assert++;
      if (busy0 !== exp_busy || busy8 !== exp_busy) begin
        n_fail++;
        $display("FAIL busy @edge %0d: got %b/%b expected %b", edge_n, busy0, busy8, exp_busy);
      end
      n_assert++;
      if (done0 !== exp_done || done8 !== exp_done) begin
        n_fail++;
        $display("FAIL done @edge %0d: got %b/%b expected %b", edge_n, done0, done8, exp_done);
      end

      if (abort_at >= 0 && writes == abort_at) begin
        rstn = 1'b0;
        #1;
        n_assert++;
        if ({wr_en0, busy0, done0, wr_en8, busy8, done8} !== 6'b0) begin
          n_fail++;
          $display("FAIL abort_outputs: got %b expected 000000", {wr_en0, busy0, done0, wr_en8, busy8, done8});
        end
        win_valid = 1'b0;
        w_we      = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        for (int k = 0; k < 25; k++) wt[k] = 0;
        exp_q.delete();
        return;
      end
      if (done_edge >= 0 && edge_n >= done_edge) finished = 1'b1;
    end
    win_valid = 1'b0;
    w_we      = 1'b0;
    n_assert++;
    if (!finished) begin
      n_fail++;
      $display("FAIL frame_timeout: got beats %0d writes %0d expected done", beat, writes);
    end
    n_assert++;
    if (writes != NW || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL write_count: got %0d (pending %0d) expected %0d", writes, exp_q.size(), NW);
    end
  endtask

  // In DONE: stream input is ignored, done is a single pulse; start re-arms to IDLE.
  task automatic test_done_hold();
    win_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_window(0, 0, 1'b1);
      tick();
      n_assert++;
      if ({wr_en0, busy0, done0, wr_en8, busy8, done8} !== 6'b0) begin
        n_fail++;
        $display("FAIL done_hold cycle %0d: got %b expected 000000", i, {wr_en0, busy0, done0, wr_en8, busy8, done8});
      end
    end
    win_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_assert++;
    if ({wr_en0, busy0, done0} !== 3'b0) begin
      n_fail++;
      $display("FAIL rearm_idle: got %b expected 000", {wr_en0, busy0, done0});
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    n_assert++;
    if ({wr_en0, busy0, done0, wr_en8, busy8, done8} !== 6'b0 ||
        wr_addr0 !== 10'd0 || wr_data0 !== 9'd0 || wr_addr8 !== 10'd0 || wr_data8 !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_state: got ctl %b addr %0d data %0d expected all zero",
               {wr_en0, busy0, done0, wr_en8, busy8, done8}, wr_addr0, wr_data0);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_const_bias();
    for (int k = 0; k < 25; k++) wt[k] = 0;
    bias_i = 7;
    fill_random(-256, 255);
    load_weights();
    stream_frame(0, -1, 1'b0);
    test_done_hold();
  endtask

  task automatic test_centre();
    for (int k = 0; k < 25; k++) wt[k] = 0;
    wt[12] = 1;
    bias_i = 0;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        pix[r][c] = (r + c) & 255;
    load_weights();
    stream_frame(0, -1, 1'b0);
    test_done_hold();
  endtask

  task automatic test_relu();
    for (int k = 0; k < 25; k++) wt[k] = 0;
    wt[12] = -1;
    bias_i = 0;
    fill_random(1, 255);
    load_weights();
    stream_frame(0, -1, 1'b0);
    test_done_hold();
    wt[12] = 0;
    bias_i = -1;
    load_weights();
    stream_frame(0, -1, 1'b0);
    test_done_hold();
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 25; k++) wt[k] = 255;
    bias_i = 0;
    fill_random(255, 255);
    load_weights();
    stream_frame(0, -1, 1'b0);
    test_done_hold();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 25; k++) wt[k] = int'($urandom_range(511)) - 256;
    bias_i = int'($urandom_range(65535)) - 32768;
    fill_random(-256, 255);
    load_weights();
    stream_frame(0, -1, 1'b0);
    test_done_hold();
    stream_frame(50, -1, 1'b0);
    test_done_hold();
  endtask

  task automatic test_abort();
    for (int k = 0; k < 25; k++) wt[k] = int'($urandom_range(511)) - 256;
    bias_i = int'($urandom_range(4095)) - 2048;
    fill_random(-256, 255);
    load_weights();
    stream_frame(0, 100, 1'b0);
    stream_frame(0, -1, 1'b0);
    test_done_hold();
    for (int k = 0; k < 25; k++) wt[k] = int'($urandom_range(511)) - 256;
    load_weights();
    stream_frame(30, -1, 1'b1);
    test_done_hold();
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; win_valid = 1'b0; w_we = 1'b0;
    w_addr = '0; w_data = '0; bias = '0;
    x_m_1 = '0; x_m_2 = '0; x_m_3 = '0; x_m_4 = '0; x_m_5 = '0;
    test_reset();
    test_const_bias();
    test_centre();
    test_relu();
    test_saturate();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
